// File: rtl/db15_pkg.sv
// Shared types and field layout for the DB15 SNAC poller.
// Bit 0 of a frame is the first bit shifted in from the adapter.
package db15_pkg;

   typedef enum logic [2:0] {
      ST_GAP      = 3'd0,
      ST_LOAD0    = 3'd1,
      ST_LOAD1    = 3'd2,
      ST_SHIFT_LO = 3'd3,
      ST_SHIFT_HI = 3'd4,
      ST_COMMIT   = 3'd5
   } db15_state_t;

   localparam int BITS_PER_PLAYER = 12;
   localparam int FRAME_BITS      = 24;
   localparam int LOAD_TICKS      = 2;
   localparam int P1_LSB          = 0;
   localparam int P2_LSB          = BITS_PER_PLAYER;
   localparam int PAD_W           = 16;

   // Widens a 12-bit player field to the 16-bit pad word; the upper bits are always zero.
   function automatic logic [PAD_W-1:0] pad_word(input logic [BITS_PER_PLAYER-1:0] bits);
      return {{(PAD_W-BITS_PER_PLAYER){1'b0}}, bits};
   endfunction

endpackage

// File: rtl/db15_tick_gen.sv
// Divider producing a one-cycle tick every CLK_DIV clk_sys cycles (a joy_clk half-period).
// While hold is high the count freezes, so the one-cycle commit step stretches the frame by one cycle.
module db15_tick_gen #(
   parameter int CLK_DIV = 48
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic hold,
   output logic tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             w_wrap;

   assign w_wrap = (r_cnt == CNT_W'(CLK_DIV - 1));
   assign tick   = w_wrap && !hold;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (!hold) begin
         r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/db15_snac_poller.sv
// DB15 SNAC adapter poller: loads the adapter shift chain, clocks in 24 active-low bits,
// and only publishes a frame once two consecutive frames agree.
module db15_snac_poller
   import db15_pkg::*;
#(
   parameter int CLK_DIV   = 48,
   parameter int GAP_TICKS = 1000
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              joy_data,
   output logic              joy_clk,
   output logic              joy_load,
   output logic [PAD_W-1:0]  joystick1,
   output logic [PAD_W-1:0]  joystick2,
   output logic              frame_done,
   output db15_state_t       dbg_state
);

   localparam int GAP_W = $clog2(GAP_TICKS + 1);
   localparam int IDX_W = $clog2(FRAME_BITS);

   db15_state_t            r_state;
   logic [GAP_W-1:0]       r_gap;
   logic [IDX_W-1:0]       r_idx;
   logic [FRAME_BITS-1:0]  r_shift;
   logic [FRAME_BITS-1:0]  r_prev;
   logic [PAD_W-1:0]       r_joy1;
   logic [PAD_W-1:0]       r_joy2;
   logic                   r_fd;
   logic                   r_jclk;
   logic                   r_jload;
   logic                   r_sync1;
   logic                   r_sync2;
   logic                   w_tick;
   logic                   w_hold;
   logic [IDX_W-1:0]       w_smp_idx;

   assign w_hold    = (r_state == ST_COMMIT);
   // Bit about to be captured: 0 when leaving LOAD1, otherwise the next index.
   assign w_smp_idx = (r_state == ST_LOAD1) ? '0 : r_idx + IDX_W'(1);

   db15_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .hold    (w_hold),
      .tick    (w_tick)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= joy_data;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_GAP;
         r_gap   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_prev  <= '0;
         r_joy1  <= '0;
         r_joy2  <= '0;
         r_fd    <= 1'b0;
         r_jclk  <= 1'b1;
         r_jload <= 1'b1;
      end else begin
         r_fd <= 1'b0;
         case (r_state)
            ST_GAP: begin
               if (w_tick) begin
                  // Once the gap has elapsed the count parks at its end value until enabled.
                  if (r_gap == GAP_W'(GAP_TICKS - 1)) begin
                     if (enable) begin
                        r_state <= ST_LOAD0;
                        r_jload <= 1'b0;
                        r_gap   <= '0;
                     end
                  end else begin
                     r_gap <= r_gap + GAP_W'(1);
                  end
               end
            end
            ST_LOAD0: begin
               if (w_tick) r_state <= ST_LOAD1;
            end
            ST_LOAD1: begin
               if (w_tick) begin
                  r_state              <= ST_SHIFT_LO;
                  r_jload              <= 1'b1;
                  r_jclk               <= 1'b0;
                  r_idx                <= '0;
                  r_shift[w_smp_idx]   <= ~r_sync2;
               end
            end
            ST_SHIFT_LO: begin
               if (w_tick) begin
                  r_state <= ST_SHIFT_HI;
                  r_jclk  <= 1'b1;
               end
            end
            ST_SHIFT_HI: begin
               if (w_tick) begin
                  if (r_idx == IDX_W'(FRAME_BITS - 1)) begin
                     r_state <= ST_COMMIT;
                  end else begin
                     r_state            <= ST_SHIFT_LO;
                     r_jclk             <= 1'b0;
                     r_idx              <= w_smp_idx;
                     r_shift[w_smp_idx] <= ~r_sync2;
                  end
               end
            end
            ST_COMMIT: begin
               if (r_shift == r_prev) begin
                  r_joy1 <= pad_word(r_shift[P1_LSB +: BITS_PER_PLAYER]);
                  r_joy2 <= pad_word(r_shift[P2_LSB +: BITS_PER_PLAYER]);
               end
               r_prev  <= r_shift;
               r_fd    <= 1'b1;
               r_state <= ST_GAP;
            end
            default: r_state <= ST_GAP;
         endcase
      end
   end

   assign joy_clk    = r_jclk;
   assign joy_load   = r_jload;
   assign joystick1  = r_joy1;
   assign joystick2  = r_joy2;
   assign frame_done = r_fd;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_db15_snac_poller.sv
// Directed bench for db15_snac_poller: an adapter model serves one 24-bit word per load,
// and a frame-schedule model predicts frame_done timing and filtered pad words.
module tb_db15_snac_poller;
   import db15_pkg::*;

   localparam int D    = 4;
   localparam int G    = 8;
   localparam int SPAN = (LOAD_TICKS + 2 * FRAME_BITS) * D + 1;  // load fall to frame_done
   localparam int P    = G * D + SPAN;                            // frame period
   localparam int F0   = G * D + SPAN;                            // first frame_done after release
   localparam int NFR  = 17;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        enable;
   wire         joy_data;
   logic        joy_clk;
   logic        joy_load;
   logic [15:0] joystick1;
   logic [15:0] joystick2;
   logic        frame_done;
   db15_state_t dbg_state;

   db15_snac_poller #(.CLK_DIV(D), .GAP_TICKS(G)) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .enable     (enable),
      .joy_data   (joy_data),
      .joy_clk    (joy_clk),
      .joy_load   (joy_load),
      .joystick1  (joystick1),
      .joystick2  (joystick2),
      .frame_done (frame_done),
      .dbg_state  (dbg_state)
   );

   always #5 clk_sys = ~clk_sys;

   int cyc;
   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   // Adapter model: raw active-low words, one per joy_load strobe, bit 0 first.
   logic [23:0] frames [0:NFR-1];
   logic [23:0] aword = 24'hFFFFFF;
   int          aidx  = 0;
   int          bitp  = 24;

   always @(negedge joy_load or posedge joy_clk) begin
      if (joy_load === 1'b0) begin
         aword = (aidx < NFR) ? frames[aidx] : 24'hFFFFFF;
         aidx  = aidx + 1;
         bitp  = 0;
      end else if (bitp < 24) begin
         bitp = bitp + 1;
      end
   end

   assign joy_data = (bitp < 24) ? aword[bitp] : 1'b1;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame-schedule model and per-cycle compare.
   logic        model_on = 1'b0;
   int          next_fd  = -1;
   int          next_k   = 0;
   int          m_last   = 11;
   logic [23:0] m_prev   = '0;
   logic [23:0] m_shift;
   logic [15:0] exp_j1   = '0;
   logic [15:0] exp_j2   = '0;
   logic        efd;
   int          rises    = 0;
   int          low_cnt  = 0;
   int          falls    = 0;
   logic        p_clk    = 1'b1;
   logic        p_load   = 1'b1;

   always @(negedge clk_sys) begin
      if (joy_load === 1'b0 && p_load === 1'b1) begin
         falls   = falls + 1;
         low_cnt = 1;
         rises   = 0;
         if (model_on) chk("load_fall_cycle", cyc, next_fd - SPAN);
      end else if (joy_load === 1'b0) begin
         low_cnt = low_cnt + 1;
      end
      if (joy_clk === 1'b1 && p_clk === 1'b0 && joy_load === 1'b1) rises = rises + 1;
      p_clk  = joy_clk;
      p_load = joy_load;

      if (model_on) begin
         efd = (next_fd >= 0) && (cyc == next_fd);
         if (efd) begin
            m_shift = ~frames[next_k];
            if (m_shift == m_prev) begin
               exp_j1 = {4'h0, m_shift[11:0]};
               exp_j2 = {4'h0, m_shift[23:12]};
            end
            m_prev = m_shift;
            chk("joy_clk_rises", rises, FRAME_BITS);
            chk("joy_load_low", low_cnt, LOAD_TICKS * D);
            next_k  = next_k + 1;
            next_fd = (next_k <= m_last) ? next_fd + P : -1;
         end
         chk("frame_done", frame_done, efd);
         chk("joystick1", joystick1, exp_j1);
         chk("joystick2", joystick2, exp_j2);
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk_sys);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_joy_clk"}, joy_clk, 1'b1);
      chk({tag, "_joy_load"}, joy_load, 1'b1);
      chk({tag, "_frame_done"}, frame_done, 1'b0);
      chk({tag, "_joystick1"}, joystick1, 16'h0000);
      chk({tag, "_joystick2"}, joystick2, 16'h0000);
      chk({tag, "_state"}, dbg_state, ST_GAP);
   endtask

   int f_snap;
   int r_rise;
   int l_res;
   int l13;

   initial begin
      frames[0]  = 24'hFFFFFE; frames[1]  = 24'hFFFFFE; frames[2]  = 24'hFFFFFF;
      frames[3]  = 24'h000FFF; frames[4]  = 24'hFFFFFF; frames[5]  = 24'h000FFF;
      frames[6]  = 24'h000FFF; frames[7]  = 24'h5A3C96; frames[8]  = 24'h5A3C96;
      frames[9]  = 24'hFFFFFE; frames[10] = 24'hFFFFFE; frames[11] = 24'hFFFFFE;
      frames[12] = 24'hFFFFFE; frames[13] = 24'hFFFFFE; frames[14] = 24'h000FFF;
      frames[15] = 24'hFFFFFE; frames[16] = 24'hFFFFFE;

      reset_n = 1'b0;
      enable  = 1'b1;
      repeat (10) @(negedge clk_sys);
      chk_reset_values("reset");

      reset_n  = 1'b1;
      next_fd  = F0;
      next_k   = 0;
      model_on = 1'b1;

      // Hand-computed pad words after selected frames.
      wait_cyc(F0 + 1);
      chk("f0_unchanged_j1", joystick1, 16'h0000);
      wait_cyc(F0 + P + 1);
      chk("f1_j1", joystick1, 16'h0001);
      chk("f1_j2", joystick2, 16'h0000);
      wait_cyc(F0 + 4 * P + 1);
      chk("glitch_j2", joystick2, 16'h0000);
      chk("glitch_j1", joystick1, 16'h0001);
      wait_cyc(F0 + 6 * P + 1);
      chk("f6_j2", joystick2, 16'h0FFF);
      chk("f6_j1", joystick1, 16'h0000);
      wait_cyc(F0 + 8 * P + 1);
      chk("f8_j1", joystick1, 16'h0369);
      chk("f8_j2", joystick2, 16'h0A5C);

      // Drop enable while frame 11 is on bit 10.
      wait_cyc(G * D + 11 * P + (LOAD_TICKS + 20) * D + 1);
      chk("drop_state", dbg_state, ST_SHIFT_LO);
      enable = 1'b0;
      wait_cyc(F0 + 11 * P + 1);
      chk("f11_j1", joystick1, 16'h0001);
      f_snap = falls;
      wait_cyc(F0 + 11 * P + 3 * P);
      chk("no_load_while_disabled", falls - f_snap, 0);
      chk("idle_state", dbg_state, ST_GAP);

      // Re-enable off the tick grid; loading must start on the very next tick.
      wait_cyc(F0 + 14 * P + 2);
      r_rise  = cyc;
      l_res   = F0 + 11 * P + D * ((r_rise + 1 - (F0 + 11 * P) + D - 1) / D);
      m_last  = 16;
      next_fd = l_res + SPAN;
      f_snap  = falls;
      enable  = 1'b1;
      wait_cyc(l_res + 1);
      chk("resume_load", falls - f_snap, 1);

      // Reset during bit 5 of frame 13.
      l13 = l_res + P;
      wait_cyc(l13 + (LOAD_TICKS + 10) * D + 1);
      #1;
      chk("pre_reset_joy_clk", joy_clk, 1'b0);
      chk("pre_reset_j1", joystick1, 16'h0001);
      model_on = 1'b0;
      reset_n  = 1'b0;
      #1;
      chk_reset_values("midframe_reset");
      repeat (10) @(negedge clk_sys);
      chk_reset_values("midframe_hold");

      reset_n  = 1'b1;
      m_prev   = '0;
      exp_j1   = '0;
      exp_j2   = '0;
      next_fd  = F0;
      next_k   = 14;
      model_on = 1'b1;
      wait_cyc(F0 + P + 1);
      chk("post_reset_no_partial", joystick1, 16'h0000);
      wait_cyc(F0 + 2 * P + 1);
      chk("post_reset_j1", joystick1, 16'h0001);
      chk("post_reset_j2", joystick2, 16'h0000);
      repeat (5) @(negedge clk_sys);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
